// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: parses make/break/extended prefixes, tracks
// Shift and Caps Lock, maps letters/digits to ASCII and buffers them in a FWFT FIFO.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CNT_W         = 8,
  parameter bit          LOWER_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic [7:0]       out_ascii,
  output logic [7:0]       out_scan,
  input  logic             out_ready,
  output logic             key_down,
  output logic [7:0]       cur_scan,
  output logic [CNT_W-1:0] press_cnt,
  output logic             shift,
  output logic             caps,
  output logic             overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodeCaps  = 8'h58;
  localparam logic [7:0] CodeLshft = 8'h12;
  localparam logic [7:0] CodeRshft = 8'h59;
  localparam logic [PtrW:0] Full   = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e             state_q;
  logic [255:0]       held_q;
  logic [7:0]         cur_scan_q;
  logic [CNT_W-1:0]   press_cnt_q;
  logic               caps_q;
  logic               overflow_q;

  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q;
  logic [15:0]        last_q;

  // Returns {is_letter, is_digit, upper-case/digit ascii}.
  function automatic logic [9:0] map_code(input logic [7:0] code);
    logic [9:0] r;
    r = 10'd0;
    case (code)
      8'h1C: r = {2'b10, 8'h41}; 8'h32: r = {2'b10, 8'h42}; 8'h21: r = {2'b10, 8'h43};
      8'h23: r = {2'b10, 8'h44}; 8'h24: r = {2'b10, 8'h45}; 8'h2B: r = {2'b10, 8'h46};
      8'h34: r = {2'b10, 8'h47}; 8'h33: r = {2'b10, 8'h48}; 8'h43: r = {2'b10, 8'h49};
      8'h3B: r = {2'b10, 8'h4A}; 8'h42: r = {2'b10, 8'h4B}; 8'h4B: r = {2'b10, 8'h4C};
      8'h3A: r = {2'b10, 8'h4D}; 8'h31: r = {2'b10, 8'h4E}; 8'h44: r = {2'b10, 8'h4F};
      8'h4D: r = {2'b10, 8'h50}; 8'h15: r = {2'b10, 8'h51}; 8'h2D: r = {2'b10, 8'h52};
      8'h1B: r = {2'b10, 8'h53}; 8'h2C: r = {2'b10, 8'h54}; 8'h3C: r = {2'b10, 8'h55};
      8'h2A: r = {2'b10, 8'h56}; 8'h1D: r = {2'b10, 8'h57}; 8'h22: r = {2'b10, 8'h58};
      8'h35: r = {2'b10, 8'h59}; 8'h1A: r = {2'b10, 8'h5A};
      8'h45: r = {2'b01, 8'h30}; 8'h16: r = {2'b01, 8'h31}; 8'h1E: r = {2'b01, 8'h32};
      8'h26: r = {2'b01, 8'h33}; 8'h25: r = {2'b01, 8'h34}; 8'h2E: r = {2'b01, 8'h35};
      8'h36: r = {2'b01, 8'h36}; 8'h3D: r = {2'b01, 8'h37}; 8'h3E: r = {2'b01, 8'h38};
      8'h46: r = {2'b01, 8'h39};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  logic       is_make, fresh, push, pop, full, do_push;
  logic [9:0] mapped;
  logic [7:0] ascii;

  // Decode the incoming byte against the pre-byte shift/caps state.
  always_comb begin
    is_make = in_valid && (state_q == StIdle) && (in_data != CodeExt) && (in_data != CodeBrk);
    fresh   = !held_q[in_data];
    mapped  = map_code(in_data);
    ascii   = mapped[7:0];
    if (mapped[9] && LOWER_DEFAULT && !(shift ^ caps_q)) ascii = mapped[7:0] + 8'h20;
    push    = is_make && (mapped[9] || mapped[8]);
    pop     = out_valid && out_ready;
    full    = (count_q == Full);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push && (!full || pop);
  end

  // Parser FSM, held-key bitmap, press counter and Caps Lock toggle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= StIdle;
      held_q      <= '0;
      cur_scan_q  <= 8'h00;
      press_cnt_q <= '0;
      caps_q      <= 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == CodeExt) begin
            state_q <= StExt;
          end else if (in_data == CodeBrk) begin
            state_q <= StBrk;
          end else begin
            held_q[in_data] <= 1'b1;
            if (fresh) begin
              press_cnt_q <= press_cnt_q + CNT_W'(1);
              cur_scan_q  <= in_data;
              if (in_data == CodeCaps) caps_q <= ~caps_q;
            end
          end
        end
        StExt:    state_q <= (in_data == CodeBrk) ? StExtBrk : StIdle;
        StBrk: begin
          held_q[in_data] <= 1'b0;
          state_q         <= StIdle;
        end
        StExtBrk: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers, occupancy, sticky overflow and last-popped entry.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= 16'h0000;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      if (do_push && !pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (!do_push && pop) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  // FIFO storage; entries are only read while valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {in_data, ascii};
  end

  // Output assembly; the head is shown directly (first-word fall-through).
  always_comb begin
    out_valid = (count_q != '0);
    {out_scan, out_ascii} = out_valid ? mem_q[rd_ptr_q] : last_q;
    key_down  = |held_q;
    shift     = held_q[CodeLshft] | held_q[CodeRshft];
    cur_scan  = cur_scan_q;
    press_cnt = press_cnt_q;
    caps      = caps_q;
    overflow  = overflow_q;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sequential successor to the combinational PS/2 scan-code-to-ASCII lookup.
- Consumes raw set-2 scan-code bytes from the PS/2 receiver and parses make, break (F0) and extended (E0) prefixes.
- Tracks Shift and Caps Lock state and converts letter and digit make codes to upper- or lower-case ASCII.
- Buffers the resulting characters in a parametrised first-word-fall-through FIFO that feeds the display/console logic, and keeps a key-press counter.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of 2, >=2
CNT_W, 8, width of press_cnt
LOWER_DEFAULT, 1, 1: letters are lower-case when Shift XOR Caps = 0; 0: letters are always upper-case, which is legacy mode

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
in_valid  in  1  in_data holds a new scan byte this cycle; single-cycle strobe
in_data  in  8  scan-code byte from the PS/2 receiver
out_valid  out  1  FIFO non-empty
out_ascii  out  8  ASCII of the FIFO head
out_scan  out  8  make code of the FIFO head
out_ready  in  1  consumer pops the head when out_valid=1
key_down  out  1  at least one non-extended key is currently held
cur_scan  out  8  make code of the most recently pressed held key
press_cnt  out  CNT_W  count of fresh key presses; wraps
shift  out  1  Left or Right Shift held
caps  out  1  Caps Lock toggle state
overflow  out  1  sticky flag: a character was dropped on a full FIFO

Behaviour:
- Reset (clrn=0, async): FSM=IDLE, FIFO empty, out_valid=0, out_ascii=0, out_scan=0, key_down=0, cur_scan=0, press_cnt=0, shift=0, caps=0, overflow=0, held bitmap cleared. Reset mid-prefix discards the partial sequence.
- Parser FSM advances only on in_valid=1; bytes are always accepted (no backpressure).
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - any other byte -> make event, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - any other byte -> extended make; ignored, go IDLE.
- BRK: any byte -> break event for that code, go IDLE.
- EXT_BRK: any byte -> ignored, go IDLE.
- Held bitmap: 256 bits, indexed by scan code. Set on make, cleared on break. key_down = OR of the bitmap. cur_scan updates on each fresh make and holds its value after release.
- Fresh make means the held bit was 0 before the byte: press_cnt += 1 (mod 2^CNT_W).
- Typematic repeat (make while held): no count increment, but the character is pushed again (autorepeat).
- Shift: 0x12 or 0x59 held sets shift; shift clears when neither is held.
- Caps Lock 0x58: caps toggles on a fresh make only; repeats and the break have no effect.
- ASCII mapping:
  - Letters: A–Z codes 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to 0x41–0x5A. Add 0x20 when LOWER_DEFAULT=1 and (shift XOR caps)=0.
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 map to 0x30–0x39, unaffected by shift and caps.
  - Other codes (including shift and caps): no push.
- Shift/caps state used for a byte is the value before that byte.
- Push: a mapped make (fresh or repeat) pushes {scan, ascii}.
- Latency: byte strobed at edge N appears with out_valid=1 at edge N+1 when the FIFO was empty.
- FIFO: FWFT; out_ascii/out_scan are valid whenever out_valid=1. Pop on out_valid & out_ready.
  - Full & push & no pop: character dropped, overflow<=1, held until reset.
  - Full & push & pop same cycle: both happen, no drop.
  - Empty & pop request: ignored.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
- When out_valid=0, out_ascii and out_scan hold their last values (0 after reset).

Test Plan:
- Reset then bytes 1C, F0, 1C with out_ready=1 -> one pop of ascii 0x61 / scan 0x1C; press_cnt=1; key_down 1 then 0; cur_scan=0x1C.
- Bytes 12, 1C, F0 1C, F0 12 -> ascii 0x41; shift=1 during, 0 after. Then 58, F0 58, 32 -> caps=1, ascii 0x42. Then 12, 32 -> ascii 0x62.
- Bytes 16 ×3 without break -> three pushes of 0x31; press_cnt increments by 1 only.
- Bytes E0 1C, E0 F0 1C, F0 5A -> no pushes, press_cnt=0, FSM back in IDLE, bitmap bit 1C stays 0.
- out_ready=0, push FIFO_DEPTH+1 letters -> out_valid=1, overflow=1, head = first letter. Then a push and a pop in the same cycle when full -> no further drop, occupancy unchanged.
- Assert clrn low after E0 F0, then after release send 1C -> ascii 0x61 pushed (treated as a make); all outputs at reset values during reset.
